eeprom_rw_sched: RTL

//  Transaction scheduler in front of the I2C byte controller (i2c_ctrl). Arbitrates between an

---
 rtl/eeprom_sched_pkg.sv | 24 ++
 rtl/eeprom_rw_sched_rr_arb2.sv | 34 +++
 rtl/eeprom_rw_sched.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/eeprom_sched_pkg.sv
// Shared types and defaults for the EEPROM read/write scheduler.
// State and grant encodings plus timing constants.
package eeprom_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_BUSY    = 2'd2,
        ST_WR_WAIT = 2'd3
    } state_t;

    typedef enum logic {
        GNT_WR = 1'b0,
        GNT_RD = 1'b1
    } gnt_t;

    localparam int TWR_DEFAULT     = 250_000;
    localparam int TIMEOUT_DEFAULT = 20_000;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/eeprom_rw_sched_rr_arb2.sv
// Two-requester round-robin arbiter (write vs read).
// Grant is combinational; last grant is registered on every grant.
module rr_arb2
    import eeprom_sched_pkg::*;
(
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic i_en,
    input  logic i_req_wr,
    input  logic i_req_rd,
    output logic o_gnt_wr,
    output logic o_gnt_rd
);

    gnt_t r_last;

    // Grant the lone requester, or the one not served last on contention
    always_comb begin
        o_gnt_wr = i_en & i_req_wr & (~i_req_rd | (r_last == GNT_RD));
        o_gnt_rd = i_en & i_req_rd & (~i_req_wr | (r_last == GNT_WR));
    end

    // Remember who was served; reset value lets write win first
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_last <= GNT_RD;
        end else if (o_gnt_wr) begin
            r_last <= GNT_WR;
        end else if (o_gnt_rd) begin
            r_last <= GNT_RD;
        end
    end

endmodule

// File: rtl/eeprom_rw_sched.sv
// EEPROM transaction scheduler in front of the I2C byte controller.
// Arbitrates write/read requests, enforces tWR and a completion watchdog.
module eeprom_rw_sched
    import eeprom_sched_pkg::*;
#(
    parameter logic ADDR_NUM       = 1'b1,
    parameter int   TWR_CYCLES     = TWR_DEFAULT,
    parameter int   TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        wr_req_valid,
    output logic        wr_req_ready,
    input  logic [15:0] wr_req_addr,
    input  logic [7:0]  wr_req_data,
    input  logic        rd_req_valid,
    output logic        rd_req_ready,
    input  logic [15:0] rd_req_addr,
    output logic        rd_rsp_valid,
    output logic [7:0]  rd_rsp_data,
    output logic        busy,
    output logic        err_timeout,
    input  logic        err_clr,
    output logic        i2c_start,
    output logic        wr_en,
    output logic        rd_en,
    output logic        addr_num,
    output logic [15:0] byte_addr,
    output logic [7:0]  wr_data,
    input  logic        i2c_end,
    input  logic [7:0]  rd_data
);

    localparam int CNT_MAX = max2(TWR_CYCLES, TIMEOUT_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TWR_LAST = CNT_W'(TWR_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_i2c_start;
    logic             r_wr_en;
    logic             r_rd_en;
    logic [15:0]      r_byte_addr;
    logic [7:0]       r_wr_data;
    logic             r_rsp_valid;
    logic [7:0]       r_rsp_data;
    logic             r_err;
    logic             w_gnt_wr;
    logic             w_gnt_rd;
    logic             w_idle;

    assign w_idle = (r_state == ST_IDLE);

    rr_arb2 u_arb (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .i_en      (w_idle),
        .i_req_wr  (wr_req_valid),
        .i_req_rd  (rd_req_valid),
        .o_gnt_wr  (w_gnt_wr),
        .o_gnt_rd  (w_gnt_rd)
    );

    assign wr_req_ready = w_gnt_wr;
    assign rd_req_ready = w_gnt_rd;
    assign rd_rsp_valid = r_rsp_valid;
    assign rd_rsp_data  = r_rsp_data;
    assign busy         = ~w_idle;
    assign err_timeout  = r_err;
    assign i2c_start    = r_i2c_start;
    assign wr_en        = r_wr_en;
    assign rd_en        = r_rd_en;
    assign addr_num     = ADDR_NUM;
    assign byte_addr    = r_byte_addr;
    assign wr_data      = r_wr_data;

    // Transaction FSM with shared cycle counter and registered outputs
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_i2c_start <= 1'b0;
            r_wr_en     <= 1'b0;
            r_rd_en     <= 1'b0;
            r_byte_addr <= '0;
            r_wr_data   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_i2c_start <= 1'b0;
            r_rsp_valid <= 1'b0;
            if (err_clr) begin
                r_err <= 1'b0;
            end
            unique case (r_state)
                ST_IDLE: begin
                    if (w_gnt_wr) begin
                        r_byte_addr <= wr_req_addr;
                        r_wr_data   <= wr_req_data;
                        r_wr_en     <= 1'b1;
                        r_i2c_start <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= ST_ISSUE;
                    end else if (w_gnt_rd) begin
                        r_byte_addr <= rd_req_addr;
                        r_rd_en     <= 1'b1;
                        r_i2c_start <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= ST_BUSY;
                end
                ST_BUSY: begin
                    if (i2c_end) begin
                        r_wr_en <= 1'b0;
                        r_rd_en <= 1'b0;
                        r_cnt   <= '0;
                        if (r_rd_en) begin
                            r_rsp_data  <= rd_data;
                            r_rsp_valid <= 1'b1;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_state <= ST_WR_WAIT;
                        end
                    end else if (r_cnt == TO_LAST) begin
                        // quiet period doubles as bus recovery
                        r_err   <= 1'b1;
                        r_wr_en <= 1'b0;
                        r_rd_en <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= ST_WR_WAIT;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_WR_WAIT: begin
                    if (r_cnt == TWR_LAST) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
